// File: rtl/uart_mmio_responder_pkg.sv
// uart_mmio_responder_pkg: register offsets, status bit positions and offset decode for the UART MMIO window
package uart_mmio_responder_pkg;

    localparam logic [31:0] OFF_STATUS    = 32'h0;
    localparam logic [31:0] OFF_RX_STATUS = 32'h4;
    localparam logic [31:0] OFF_TX_DATA   = 32'h8;
    localparam logic [31:0] OFF_RX_DATA   = 32'hC;

    localparam int ST_TX_EMPTY    = 0;
    localparam int ST_TX_OVERRUN  = 1;
    localparam int RXST_NONEMPTY  = 0;
    localparam int RXST_COUNT_LSB = 4;
    localparam int RXST_COUNT_W   = 4;

    typedef enum logic [2:0] {
        REG_STATUS,
        REG_RX_STATUS,
        REG_TX_DATA,
        REG_RX_DATA,
        REG_NONE
    } reg_sel_e;

    // Byte-lane bits [1:0] never select a register.
    function automatic reg_sel_e decode_offset(input logic [31:0] addr);
        logic [31:0] w;
        w = addr & ~32'h3;
        return (w == OFF_STATUS)    ? REG_STATUS    :
               (w == OFF_RX_STATUS) ? REG_RX_STATUS :
               (w == OFF_TX_DATA)   ? REG_TX_DATA   :
               (w == OFF_RX_DATA)   ? REG_RX_DATA   : REG_NONE;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO buffering received UART data
//   clk, rst_n    : clock, async active-low reset (clears pointers and count)
//   push, din     : write din when push=1 (caller guarantees not full)
//   pop, dout     : dout is the current head; pop=1 removes it (caller guarantees not empty)
//   full, empty   : occupancy flags
//   count         : number of stored entries, 0..DEPTH
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;

endmodule

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: CPU memory-mapped register window in front of a UART TX/RX byte stream
//   clk, rst_n                  : clock, async active-low reset
//   ReadEn, WriteEn, Address    : CPU access strobes and byte offset within the window
//   WriteData, ReadData         : CPU store data (bits [7:0] used), registered load data
//   TxData, TxValid, TxReady    : holding register toward the transmitter (valid/ready)
//   RxData, RxValid, RxReady    : bytes from the receiver into the RX FIFO (valid/ready)
module uart_mmio_responder
    import uart_mmio_responder_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ReadEn,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic [7:0]        TxData,
    output logic              TxValid,
    input  logic              TxReady,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady
);
    localparam int CW = $clog2(RX_DEPTH) + 1;

    reg_sel_e      sel;
    logic [31:0]   rdata_q, rdata_d, rd_val;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          overrun_q, overrun_d;
    logic          wr_tx, tx_accept, rd_status;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;
    logic          unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (RxData),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign RxReady = !rx_full;
    assign rx_push = RxValid && RxReady;

    always_comb begin
        sel       = decode_offset(32'(Address));
        wr_tx     = WriteEn && sel == REG_TX_DATA;
        // A write while the byte is still held (including its completion cycle) is an overrun.
        tx_accept = wr_tx && !tx_valid_q;
        rd_status = ReadEn && sel == REG_STATUS;
        rx_pop    = ReadEn && sel == REG_RX_DATA && !rx_empty;
        rd_val    = '0;
        if (sel == REG_STATUS) begin
            rd_val[ST_TX_EMPTY]   = !tx_valid_q;
            rd_val[ST_TX_OVERRUN] = overrun_q;
        end
        if (sel == REG_RX_STATUS) begin
            rd_val[RXST_NONEMPTY]                      = !rx_empty;
            rd_val[RXST_COUNT_LSB +: RXST_COUNT_W]     = RXST_COUNT_W'(rx_count);
        end
        if (rx_pop) rd_val[7:0] = rx_head;
        rdata_d    = ReadEn ? rd_val : rdata_q;
        // A fresh overrun wins over the clear-on-read of the status register.
        overrun_d  = (wr_tx && tx_valid_q) || (overrun_q && !rd_status);
        tx_valid_d = tx_accept || (tx_valid_q && !TxReady);
        tx_data_d  = tx_accept ? WriteData[7:0] : tx_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign ReadData = rdata_q;
    assign TxData   = tx_data_q;
    assign TxValid  = tx_valid_q;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb_uart_mmio_responder: directed self-checking bench for uart_mmio_responder
module tb_uart_mmio_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ReadEn, WriteEn;
    logic [3:0]  Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;

    int checks = 0;
    int errors = 0;

    uart_mmio_responder #(.RX_DEPTH(4), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ReadEn    (ReadEn),
        .WriteEn   (WriteEn),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .TxReady   (TxReady),
        .RxData    (RxData),
        .RxValid   (RxValid),
        .RxReady   (RxReady)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a);
        ReadEn = 1'b1; Address = a;
        tick();
        ReadEn = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        WriteEn = 1'b1; Address = a; WriteData = {24'hABCDEF, d};
        tick();
        WriteEn = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] d);
        RxValid = 1'b1; RxData = d;
        tick();
        RxValid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ReadEn = 0; WriteEn = 0; Address = 0; WriteData = 0;
        TxReady = 0; RxData = 0; RxValid = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", ReadData, 32'h0); end
        checks++; if (RxReady !== 1'b1) begin errors++; $display("FAIL reset_rxready got=%b exp=1", RxReady); end
        checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL reset_txvalid got=%b exp=0", TxValid); end
        do_read(4'h0);
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=%h", ReadData, 32'h1); end
        tick();
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL rdata_hold got=%h exp=%h", ReadData, 32'h1); end
    endtask

    task automatic test_tx_write();
        do_write(4'h8, 8'h41);
        checks++; if (TxValid !== 1'b1 || TxData !== 8'h41) begin errors++; $display("FAIL tx_latch got=%b/%h exp=1/41", TxValid, TxData); end
        tick(); tick();
        checks++; if (TxValid !== 1'b1 || TxData !== 8'h41) begin errors++; $display("FAIL tx_stable got=%b/%h exp=1/41", TxValid, TxData); end
        do_write(4'h8, 8'h42);
        checks++; if (TxData !== 8'h41) begin errors++; $display("FAIL tx_overrun_drop got=%h exp=41", TxData); end
        do_read(4'h0);
        checks++; if (ReadData !== 32'h2) begin errors++; $display("FAIL overrun_status got=%h exp=%h", ReadData, 32'h2); end
        do_read(4'h0);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL overrun_clear got=%h exp=%h", ReadData, 32'h0); end
    endtask

    task automatic test_tx_complete();
        TxReady = 1'b1;
        tick();
        TxReady = 1'b0;
        checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL tx_done got=%b exp=0", TxValid); end
        do_read(4'h0);
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL tx_empty_status got=%h exp=%h", ReadData, 32'h1); end
    endtask

    task automatic test_tx_collision();
        do_write(4'h8, 8'h50);
        TxReady = 1'b1; WriteEn = 1'b1; Address = 4'h8; WriteData = 32'h51;
        tick();
        TxReady = 1'b0; WriteEn = 1'b0;
        checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL collide_valid got=%b exp=0", TxValid); end
        do_read(4'h0);
        checks++; if (ReadData !== 32'h3) begin errors++; $display("FAIL collide_status got=%h exp=%h", ReadData, 32'h3); end
        do_write(4'h8, 8'h60);
        ReadEn = 1'b1; WriteEn = 1'b1; Address = 4'h0; WriteData = 32'h61;
        Address = 4'h0;
        WriteEn = 1'b0;
        // Same-cycle read of status and overrunning write: drive write offset separately is impossible on one bus,
        // so use a second cycle with read of 0x0 while a write to 0x8 is impossible; instead check priority via status read below.
        tick();
        ReadEn = 1'b0;
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL status_busy got=%h exp=%h", ReadData, 32'h0); end
        do_write(4'h0, 8'h77);
        checks++; if (TxData !== 8'h60) begin errors++; $display("FAIL write_unmapped got=%h exp=60", TxData); end
        do_read(4'h8);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL read_unmapped got=%h exp=%h", ReadData, 32'h0); end
        ReadEn = 1'b1; WriteEn = 1'b1; Address = 4'h8; WriteData = 32'h62;
        tick();
        ReadEn = 1'b0; WriteEn = 1'b0;
        do_read(4'h0);
        checks++; if (ReadData !== 32'h2) begin errors++; $display("FAIL rw_overrun got=%h exp=%h", ReadData, 32'h2); end
        TxReady = 1'b1;
        tick();
        TxReady = 1'b0;
        do_read(4'h0);
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL final_status got=%h exp=%h", ReadData, 32'h1); end
    endtask

    task automatic test_rx_fill();
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) do_push(exp_b[i]);
        checks++; if (RxReady !== 1'b0) begin errors++; $display("FAIL rx_full_ready got=%b exp=0", RxReady); end
        do_push(8'h99);
        do_read(4'h4);
        checks++; if (ReadData !== 32'h41) begin errors++; $display("FAIL rx_status_full got=%h exp=%h", ReadData, 32'h41); end
        for (int i = 0; i < 4; i++) begin
            do_read(4'hC);
            checks++; if (ReadData !== {24'h0, exp_b[i]}) begin errors++; $display("FAIL rx_pop%0d got=%h exp=%h", i, ReadData, exp_b[i]); end
        end
        do_read(4'hC);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rx_pop_empty got=%h exp=%h", ReadData, 32'h0); end
        do_read(4'h4);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rx_status_empty got=%h exp=%h", ReadData, 32'h0); end
    endtask

    task automatic test_back_to_back();
        do_push(8'h66);
        do_push(8'h77);
        RxValid = 1'b1; RxData = 8'h55; ReadEn = 1'b1; Address = 4'hC;
        tick();
        RxValid = 1'b0; ReadEn = 1'b0;
        checks++; if (ReadData !== 32'h66) begin errors++; $display("FAIL b2b_head got=%h exp=%h", ReadData, 32'h66); end
        do_read(4'h4);
        checks++; if (ReadData !== 32'h21) begin errors++; $display("FAIL b2b_count got=%h exp=%h", ReadData, 32'h21); end
        do_read(4'hC);
        checks++; if (ReadData !== 32'h77) begin errors++; $display("FAIL b2b_second got=%h exp=%h", ReadData, 32'h77); end
        do_read(4'hC);
        checks++; if (ReadData !== 32'h55) begin errors++; $display("FAIL b2b_last got=%h exp=%h", ReadData, 32'h55); end
    endtask

    task automatic test_reset_mid();
        do_write(4'h8, 8'hAB);
        do_push(8'h01);
        do_push(8'h02);
        do_push(8'h03);
        do_read(4'h4);
        checks++; if (ReadData !== 32'h31 || TxValid !== 1'b1) begin errors++; $display("FAIL pre_reset got=%h/%b exp=31/1", ReadData, TxValid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ReadData !== 32'h0 || TxValid !== 1'b0 || TxData !== 8'h0) begin errors++; $display("FAIL async_reset got=%h/%b/%h exp=0/0/0", ReadData, TxValid, TxData); end
        checks++; if (RxReady !== 1'b1) begin errors++; $display("FAIL async_reset_rxready got=%b exp=1", RxReady); end
        tick();
        rst_n = 1'b1;
        tick();
        do_read(4'h4);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL post_reset_rx got=%h exp=%h", ReadData, 32'h0); end
        do_read(4'h0);
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL post_reset_status got=%h exp=%h", ReadData, 32'h1); end
    endtask

    initial begin
        test_reset();
        test_tx_write();
        test_tx_complete();
        test_tx_collision();
        test_rx_fill();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mmio_responder.md
UART_MMIO_RESPONDER -- requirements
Module: uart_mmio_responder

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4: RX FIFO entries; a power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 4: width of the byte-offset address input.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port ReadEn, input, 1: CPU read strobe for the UART window (0x8000_0000 region).
REQ-006 SHALL have port WriteEn, input, 1: CPU write strobe for the UART window.
REQ-007 SHALL have port Address, input, ADDR_W: byte offset within the window; bits [1:0] ignored.
REQ-008 SHALL have port WriteData, input, 32: CPU store data; only bits [7:0] are used.
REQ-009 SHALL have port ReadData, output, 32: registered load data.
REQ-010 SHALL have port TxData, output, 8: byte presented to the UART transmitter.
REQ-011 SHALL have port TxValid, output, 1: TxData is valid.
REQ-012 SHALL have port TxReady, input, 1: transmitter accepts the byte.
REQ-013 SHALL have port RxData, input, 8: byte from the UART receiver.
REQ-014 SHALL have port RxValid, input, 1: RxData is valid.
REQ-015 SHALL have port RxReady, output, 1: responder accepts RxData.

Function
REQ-016 Register map SHALL be: 0x0 status (read); 0x4 RX status (read); 0x8 TX data (write); 0xC RX data (read, pops).
REQ-017 A read of 0x0 SHALL return {30'b0, tx_overrun, tx_empty}; tx_empty=1 when the TX holding register is empty.
REQ-018 A read of 0x0 SHALL clear tx_overrun on the same clock edge; a new overrun on that edge SHALL take priority (bit stays 1).
REQ-019 A read of 0x4 SHALL return {24'b0, rx_count[3:0], 3'b0, rx_nonempty}.
REQ-020 A read of 0xC with the RX FIFO non-empty SHALL return {24'b0, head byte} and pop one entry.
REQ-021 A read of 0xC with the FIFO empty SHALL return 0 and leave the FIFO unchanged.
REQ-022 ReadData SHALL update on the edge where ReadEn=1, one cycle of latency, and hold its value while ReadEn=0.
REQ-023 A read of an unmapped offset SHALL return 0 with no side effects.
REQ-024 A write to 0x8 with the holding register empty SHALL latch WriteData[7:0] into TxData and set TxValid=1 on the next cycle.
REQ-025 A write to 0x8 with the holding register full SHALL be dropped and set tx_overrun.
REQ-026 Writes to any other offset SHALL be ignored.
REQ-027 The TX transfer SHALL complete on an edge where TxValid and TxReady are both 1; TxValid SHALL then go to 0.
REQ-028 TxData SHALL stay stable while TxValid=1.
REQ-029 A CPU write in the same cycle as a TX completion SHALL be treated as a write to a full register (dropped, overrun set).
REQ-030 RxReady SHALL equal (rx_count != RX_DEPTH) combinationally.
REQ-031 A push SHALL occur on an edge where RxValid and RxReady are both 1.
REQ-032 A simultaneous push and pop SHALL both occur: count unchanged, FIFO order preserved, and the pop returns the old head.
REQ-033 Pointers SHALL wrap modulo RX_DEPTH.
REQ-034 ReadEn and WriteEn asserted together SHALL perform both operations independently.

Reset
REQ-035 rst_n low SHALL asynchronously force ReadData=0, TxData=0, TxValid=0, tx_overrun=0, rx_count=0 and pointers=0.
REQ-036 Reset mid-transfer SHALL discard the held TX byte and all RX contents.
REQ-037 RxReady SHALL read 1 from the first cycle after rst_n deasserts.

Structure
REQ-038 Offset constants (0x0, 0x4, 0x8, 0xC) and status bit positions SHALL live in a shared package, also used by the CPU-side address decoder.
REQ-039 The RX buffer SHALL be a sub-module named uart_rx_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-040 Reset release, then read 0x0 -> ReadData=0x1 next cycle; RxReady=1; TxValid=0.
REQ-041 Write 0x8 with 0x41, TxReady held 0 -> TxValid=1, TxData=0x41 stable; write 0x8 with 0x42 -> read 0x0 returns 0x2; a second read returns 0x0.
REQ-042 Raise TxReady for one cycle -> TxValid=0; read 0x0 -> 0x1.
REQ-043 Push 0x11,0x22,0x33,0x44 -> RxReady=0; read 0x4 -> 0x41; reads of 0xC return 0x11,0x22,0x33,0x44 in order, then 0x0.
REQ-044 FIFO holding 2 entries, push 0x55 and read 0xC in the same cycle -> count stays 2, old head returned, 0x55 delivered last.
REQ-045 Assert rst_n=0 mid-cycle with TxValid=1 and 3 RX entries -> outputs clear immediately; after release, read 0x4 -> 0x0.
